// File: rtl/serializer_gearbox.sv
// Wide-to-narrow serializer: each accepted IN_WIDTH word is emitted as up to RATIO beats.
// Optional one-word input skid register enabled by SERIALIZER_GEARBOX_SKID_EN.
module serializer_gearbox #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int IN_WIDTH = OUT_WIDTH * RATIO,
    localparam int CNTW     = $clog2(RATIO + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [CNTW-1:0]      in_beats,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy
);

    logic [IN_WIDTH-1:0] buf_q, buf_d;
    logic [CNTW-1:0]     rem_q, rem_d;
    logic                last_q, last_d;
    logic                first_q, first_d;

    logic [CNTW-1:0]     beats_eff;
    logic                out_fire;
    logic                can_load;
    logic                accept;
    logic                load_en;
    logic [IN_WIDTH-1:0] src_data;
    logic [CNTW-1:0]     src_beats;
    logic                src_last;

    always_comb begin
        beats_eff = in_beats;
        if (in_beats == '0 || in_beats > CNTW'(RATIO)) beats_eff = CNTW'(RATIO);
    end

    assign out_valid = (rem_q != '0);
    assign out_fire  = out_valid && out_ready;
    // Main register can take a new word at this edge: empty, or its final beat is leaving.
    assign can_load  = (rem_q == '0) || (rem_q == CNTW'(1) && out_ready);

`ifdef SERIALIZER_GEARBOX_SKID_EN
    logic [IN_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CNTW-1:0]     skid_beats_q, skid_beats_d;
    logic                skid_last_q, skid_last_d;
    logic                skid_full_q, skid_full_d;
    logic                in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q;
    assign busy     = out_valid || skid_full_q;

    // A full skid always drains first; in_ready is low while it is full, so no accept collides.
    always_comb begin
        src_data     = in_data;
        src_beats    = beats_eff;
        src_last     = in_last;
        skid_data_d  = skid_data_q;
        skid_beats_d = skid_beats_q;
        skid_last_d  = skid_last_q;
        skid_full_d  = skid_full_q;
        if (skid_full_q) begin
            src_data  = skid_data_q;
            src_beats = skid_beats_q;
            src_last  = skid_last_q;
        end
        load_en = can_load && (skid_full_q || accept);
        if (skid_full_q && can_load) begin
            skid_full_d = 1'b0;
        end else if (accept && !can_load) begin
            skid_full_d  = 1'b1;
            skid_data_d  = in_data;
            skid_beats_d = beats_eff;
            skid_last_d  = in_last;
        end
        in_ready_d = !skid_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data_q  <= '0;
            skid_beats_q <= '0;
            skid_last_q  <= 1'b0;
            skid_full_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_data_q  <= skid_data_d;
            skid_beats_q <= skid_beats_d;
            skid_last_q  <= skid_last_d;
            skid_full_q  <= skid_full_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready  = can_load;
    assign accept    = in_valid && can_load;
    assign busy      = out_valid;
    assign load_en   = accept;
    assign src_data  = in_data;
    assign src_beats = beats_eff;
    assign src_last  = in_last;
`endif

    always_comb begin
        buf_d   = buf_q;
        rem_d   = rem_q;
        last_d  = last_q;
        first_d = first_q;
        if (load_en) begin
            buf_d   = src_data;
            rem_d   = src_beats;
            last_d  = src_last;
            first_d = 1'b1;
        end else if (out_fire) begin
            rem_d   = rem_q - CNTW'(1);
            first_d = 1'b0;
            buf_d   = LSB_FIRST ? (buf_q >> OUT_WIDTH) : (buf_q << OUT_WIDTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        if (LSB_FIRST) out_data = buf_q[OUT_WIDTH-1:0];
        else           out_data = buf_q[IN_WIDTH-1 -: OUT_WIDTH];
    end

    assign out_first = first_q;
    assign out_last  = last_q && (rem_q == CNTW'(1));

`ifndef SYNTHESIS
    property p_in_hold;
        @(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=>
            (in_valid && $stable(in_data) && $stable(in_beats) && $stable(in_last));
    endproperty
    a_in_hold: assert property (p_in_hold)
        else $error("serializer_gearbox: input dropped or changed while stalled");
`endif

endmodule
